// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one 1-bit add cell stepped LSB-first
// under a start/busy/done controller.

module HalfAdder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_ss;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_ha1_s;
    logic             w_ha1_c;
    logic             w_bit;
    logic             w_ha2_c;
    logic             w_carry_nx;
    logic [WIDTH-1:0] w_ss_nx;
    logic             w_accept;
    logic             w_last;

    // Full-adder cell: two half adders, carries merged by an OR.
    HalfAdder u_ha1 (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .sum  (w_ha1_s),
        .carry(w_ha1_c)
    );

    HalfAdder u_ha2 (
        .a    (w_ha1_s),
        .b    (r_carry),
        .sum  (w_bit),
        .carry(w_ha2_c)
    );

    assign w_carry_nx = w_ha1_c | w_ha2_c;
    assign w_ss_nx    = {w_bit, r_ss[WIDTH-1:1]};
    assign w_accept   = (r_state != RUN) && start;
    assign w_last     = (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    w_state_nx = start ? RUN : IDLE;
            RUN:     w_state_nx = w_last ? DONE : RUN;
            DONE:    w_state_nx = start ? RUN : IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Result registers only move on the last bit, so no partial sum leaks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_ss    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (w_accept) begin
            r_sa    <= a;
            r_sb    <= b;
            r_ss    <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_ss    <= w_ss_nx;
            r_carry <= w_carry_nx;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                sum  <= w_ss_nx;
                cout <= w_carry_nx;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected
// {cout,sum}; a negedge monitor pops and compares on each done pulse.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] sbq[$];
    logic [7:0] last_sum;
    logic       prev_done = 1'b0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            chk("busy_with_done", {31'b0, busy}, 0);
            chk("done_twice", {31'b0, prev_done}, 0);
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("result", {23'b0, cout, sum}, {23'b0, sbq.pop_front()});
            end
        end
        prev_done <= rst ? 1'b0 : done;
    end

    task automatic issue(input logic [7:0] xa, input logic [7:0] xb,
                         input logic xc, input logic [8:0] exp,
                         input bit push);
        @(negedge clk);
        a = xa;
        b = xb;
        cin = xc;
        start = 1'b1;
        if (push) sbq.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 1);
    endtask

    task automatic wait_done(output int cyc, input bit hold);
        cyc = 0;
        while (!done && cyc < 40) begin
            if (hold) chk("sum_hold", {24'b0, sum}, {24'b0, last_sum});
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    int         c;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    bit         seen;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        last_sum = '0;
        #12;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_sum", {24'b0, sum}, 0);
        chk("rst_cout", {31'b0, cout}, 0);
        @(negedge clk);
        rst = 1'b0;

        issue(8'h0F, 8'h01, 1'b0, 9'h010, 1);
        wait_done(c, 1);
        chk("lat_0f01", c, 8);
        last_sum = 8'h10;

        issue(8'hFF, 8'h01, 1'b0, 9'h100, 1);
        wait_done(c, 1);
        last_sum = 8'h00;

        issue(8'hA5, 8'h5A, 1'b0, 9'h0FF, 1);
        wait_done(c, 1);
        last_sum = 8'hFF;

        issue(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1);
        wait_done(c, 1);
        chk("lat_ffff", c, 8);

        // Async reset in the middle of an add; nothing may be published.
        issue(8'h80, 8'h80, 1'b0, 9'h000, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_done", {31'b0, done}, 0);
        chk("arst_sum", {24'b0, sum}, 0);
        chk("arst_cout", {31'b0, cout}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("no_done_after_rst", {31'b0, seen}, 0);
        last_sum = 8'h00;

        issue(8'h10, 8'h20, 1'b0, 9'h030, 1);
        wait_done(c, 1);
        chk("lat_fresh", c, 8);
        last_sum = 8'h30;

        issue(8'h03, 8'h04, 1'b0, 9'h007, 1);
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c, 1);
        last_sum = 8'h07;

        @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        sbq.push_back(9'h002);
        sbq.push_back(9'h002);
        @(negedge clk);
        wait_done(c, 0);
        chk("b2b_lat1", c, 8);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 1);
        wait_done(c, 0);
        chk("b2b_lat2", c, 8);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            issue(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'b0, rc}, 1);
            wait_done(c, 0);
        end

        repeat (2) @(negedge clk);
        chk("queue_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
